// File: rtl/exp_shift_add_if.sv
`default_nettype none
// ============================================================================
// Module      : exp_shift_add_if
// Description : Bundle between the shift-add exponential core and its
//               controller/selection neighbours. The master drives start,
//               x_in and the selection results (i, int_or_fra); the slave
//               (the core) drives the residual, handshake and result.
//   start      master->slave  start pulse
//   x_in       master->slave  exponent argument, Q4.11
//   i          master->slave  selection frac-step index
//   int_or_fra master->slave  selection step kind (1 = ln2 step)
//   data       slave->master  current residual, feeds selection
//   busy/done  slave->master  run handshake
//   y          slave->master  result e^x_in, Q(Y_W-16).16 by default
//   iter_cnt   slave->master  steps applied in last run
//   err        slave->master  abnormal termination flag
// Revision    : 1.0 - initial release
// ============================================================================
interface exp_shift_add_if #(
    parameter int X_W = 15,
    parameter int Y_W = 40
);
    logic           start;
    logic [X_W-1:0] x_in;
    logic [4:0]     i;
    logic           int_or_fra;
    logic [X_W-1:0] data;
    logic           busy;
    logic           done;
    logic [Y_W-1:0] y;
    logic [4:0]     iter_cnt;
    logic           err;

    modport master (
        output start, x_in, i, int_or_fra,
        input  data, busy, done, y, iter_cnt, err
    );

    modport slave (
        input  start, x_in, i, int_or_fra,
        output data, busy, done, y, iter_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/exp_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : exp_shift_add
// Description : Iterative shift-add e^x core. Holds the residual x, presents
//               it to the selection block, and applies the step selection
//               returns: an int step (x -= ln2, y <<= 1) or a frac step
//               (x -= ln(1+2^-i), y += y>>i). y starts at 1.0.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : exp_shift_add_if.slave (start/x_in/i/int_or_fra in,
//          data/busy/done/y/iter_cnt/err out)
// Build option: define EXP_ROUND_EN to round-half-up the y>>i term of frac
//               steps; otherwise it is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_shift_add #(
    parameter int X_W      = 15,
    parameter int Y_W      = 40,
    parameter int FRAC_Y   = 16,
    parameter int SEL_LAT  = 1,
    parameter int MAX_ITER = 31
) (
    input  wire logic         clk,
    input  wire logic         rst,
    exp_shift_add_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_UPD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [X_W-1:0] c_ln2       = X_W'(1419);
    localparam logic [1:0]     c_wait_last = 2'(SEL_LAT - 1);
    localparam logic [4:0]     c_max_iter  = 5'(MAX_ITER);
    localparam logic [Y_W-1:0] c_one       = Y_W'(1) << FRAC_Y;

    // ln(1+2^-idx) in Q11; indices outside 1..11 are below table resolution.
    function automatic logic [X_W-1:0] lut_f(input logic [4:0] idx);
        logic [X_W-1:0] v;
        case (idx)
            5'd1:    v = X_W'(830);
            5'd2:    v = X_W'(457);
            5'd3:    v = X_W'(241);
            5'd4:    v = X_W'(124);
            5'd5:    v = X_W'(63);
            5'd6:    v = X_W'(32);
            5'd7:    v = X_W'(16);
            5'd8:    v = X_W'(8);
            5'd9:    v = X_W'(4);
            5'd10:   v = X_W'(2);
            5'd11:   v = X_W'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t         state_q, state_d;
    logic [X_W-1:0] data_q,  data_d;
    logic [Y_W-1:0] y_q,     y_d;
    logic [4:0]     iter_q,  iter_d;
    logic           err_q,   err_d;
    logic           busy_q,  busy_d;
    logic [1:0]     wait_q,  wait_d;

    logic           w_frac_ok;
    logic [X_W-1:0] w_sel_lut;
    logic [Y_W:0]   w_incr;
    logic [Y_W:0]   w_frac_sum;
    logic [4:0]     w_iter_inc;

    assign w_frac_ok  = (bus.i >= 5'd1) && (bus.i <= 5'd11);
    assign w_sel_lut  = bus.int_or_fra ? c_ln2 : lut_f(bus.i);
    assign w_iter_inc = iter_q + 5'd1;

    // One extra bit on the sum catches overflow for the saturation rule.
`ifdef EXP_ROUND_EN
    assign w_incr = ({1'b0, y_q} + ((Y_W+1)'(1) << (bus.i - 5'd1))) >> bus.i;
`else
    assign w_incr = {1'b0, y_q} >> bus.i;
`endif
    assign w_frac_sum = {1'b0, y_q} + w_incr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            y_q     <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            y_q     <= y_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        y_d     = y_q;
        iter_d  = iter_q;
        err_d   = err_q;
        busy_d  = busy_q;
        wait_d  = wait_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    data_d  = bus.x_in;
                    y_d     = c_one;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = '0;
                    state_d = ST_SEL;
                end
            end

            // Residual is held stable while selection settles.
            ST_SEL: begin
                if (wait_q == c_wait_last) begin
                    wait_d  = '0;
                    state_d = ST_UPD;
                end else begin
                    wait_d  = wait_q + 2'd1;
                end
            end

            ST_UPD: begin
                if (data_q == '0) begin
                    state_d = ST_DONE;
                end else if (!bus.int_or_fra && !w_frac_ok) begin
                    // Residual is below table resolution: normal finish.
                    state_d = ST_DONE;
                end else if (w_sel_lut > data_q) begin
                    // Selection asked for more than is left.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.int_or_fra && y_q[Y_W-1]) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!bus.int_or_fra && w_frac_sum[Y_W]) begin
                    y_d     = '1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    data_d  = data_q - w_sel_lut;
                    y_d     = bus.int_or_fra ? {y_q[Y_W-2:0], 1'b0}
                                             : w_frac_sum[Y_W-1:0];
                    iter_d  = w_iter_inc;
                    if (w_iter_inc == c_max_iter) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEL;
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.data     = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.y        = y_q;
    assign bus.iter_cnt = iter_q;
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_exp_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_shift_add
// Description : Self-checking bench for exp_shift_add. Models the selection
//               block (registered, one cycle latency) and compares each run
//               against an arithmetic reference of the e^x iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_shift_add;

    localparam int X_W     = 15;
    localparam int Y_W     = 40;
    localparam int SEL_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   force_bad = 1'b0;

    int lut [12] = '{0, 830, 457, 241, 124, 63, 32, 16, 8, 4, 2, 1};

    exp_shift_add_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

    exp_shift_add #(
        .X_W(X_W), .Y_W(Y_W), .FRAC_Y(16), .SEL_LAT(SEL_LAT), .MAX_ITER(31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Selection model: int if data>=ln2, else smallest i with LUT[i]<=data.
    always @(posedge clk) begin
        int d;
        int k;
        d = int'(bus.data);
        k = 0;
        for (int n = 11; n >= 1; n--)
            if (lut[n] <= d) k = n;
        if (force_bad) begin
            bus.int_or_fra <= 1'b0;
            bus.i          <= 5'd1;
        end else if (d >= 1419) begin
            bus.int_or_fra <= 1'b1;
            bus.i          <= 5'd0;
        end else begin
            bus.int_or_fra <= 1'b0;
            bus.i          <= 5'(k);
        end
    end

    // Reference: iterate e^x directly on integers.
    task automatic ref_run(input int x, output longint unsigned yv, output int n,
                           output bit e, output int r, output int nupd);
        longint unsigned yy;
        longint unsigned add;
        int k;
        yy = 64'd1 << 16; r = x; n = 0; e = 0; nupd = 0;
        for (int s = 0; s < 64; s++) begin
            nupd++;
            if (r == 0) break;
            if (r >= 1419) begin
                if (yy >= (64'd1 << 39)) begin e = 1; break; end
                r -= 1419; yy = yy * 2;
            end else begin
                k = 0;
                for (int m = 11; m >= 1; m--) if (lut[m] <= r) k = m;
                if (k == 0) break;
`ifdef EXP_ROUND_EN
                add = (yy + (64'd1 << (k - 1))) >> k;
`else
                add = yy >> k;
`endif
                if (yy + add >= (64'd1 << 40)) begin
                    yy = (64'd1 << 40) - 1; e = 1; break;
                end
                yy += add; r -= lut[k];
            end
            n++;
            if (n == 31) begin e = 1; break; end
        end
        yv = yy;
    endtask

    task automatic run(input logic [X_W-1:0] x, output int cyc, output bit to);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = x;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        to  = 1'b0;
        while (!bus.done) begin
            if (cyc >= 400) begin to = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.data !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.y !== '0 || bus.iter_cnt !== '0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset: data=%0d busy=%b done=%b y=%0h it=%0d err=%b exp all 0",
                     bus.data, bus.busy, bus.done, bus.y, bus.iter_cnt, bus.err);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [X_W-1:0] xs [4] = '{15'd0, 15'd1419, 15'd830, 15'd2048};
        logic [Y_W-1:0] ys [4] = '{40'h10000, 40'h20000, 40'h18000, 40'd178181};
        int             ns [4] = '{0, 1, 1, 5};
        int             cs [4] = '{3, 5, 5, 13};
        int cyc;
        bit to;
        for (int t = 0; t < 4; t++) begin
            run(xs[t], cyc, to);
            checks++;
            if (to) begin
                errors++; $display("FAIL dir_timeout x=%0d got no done exp done", xs[t]);
                continue;
            end
            checks++;
            if (bus.y !== ys[t] || bus.iter_cnt !== 5'(ns[t]) || bus.err !== 1'b0 ||
                bus.data !== '0) begin
                errors++;
                $display("FAIL dir_result x=%0d y=%0h it=%0d err=%b data=%0d exp y=%0h it=%0d err=0 data=0",
                         xs[t], bus.y, bus.iter_cnt, bus.err, bus.data, ys[t], ns[t]);
            end
            checks++;
            if (cyc != cs[t]) begin
                errors++; $display("FAIL dir_latency x=%0d got %0d exp %0d", xs[t], cyc, cs[t]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.y !== ys[t]) begin
                errors++;
                $display("FAIL dir_after_done done=%b busy=%b y=%0h exp 0 0 %0h",
                         bus.done, bus.busy, bus.y, ys[t]);
            end
        end
    endtask

    task automatic test_bad_select;
        int cyc;
        bit to;
        force_bad = 1'b1;
        run(15'd100, cyc, to);
        force_bad = 1'b0;
        checks++;
        if (to || bus.err !== 1'b1 || bus.y !== 40'h10000 || bus.iter_cnt !== 5'd0 ||
            bus.data !== 15'd100 || cyc != 3) begin
            errors++;
            $display("FAIL bad_select to=%b err=%b y=%0h it=%0d data=%0d cyc=%0d exp 0 1 10000 0 100 3",
                     to, bus.err, bus.y, bus.iter_cnt, bus.data, cyc);
        end
    endtask

    task automatic test_random;
        longint unsigned ey;
        int en, er, nupd, cyc, x;
        bit ee, to;
        for (int t = 0; t < 40; t++) begin
            x = int'($urandom_range(0, 32767));
            ref_run(x, ey, en, ee, er, nupd);
            run(15'(x), cyc, to);
            checks++;
            if (to || bus.y !== Y_W'(ey) || bus.iter_cnt !== 5'(en) || bus.err !== ee ||
                bus.data !== X_W'(er) || cyc != 1 + nupd * (SEL_LAT + 1)) begin
                errors++;
                $display("FAIL random x=%0d to=%b y=%0d it=%0d err=%b data=%0d cyc=%0d exp y=%0d it=%0d err=%b data=%0d cyc=%0d",
                         x, to, bus.y, bus.iter_cnt, bus.err, bus.data, cyc,
                         ey, en, ee, er, 1 + nupd * (SEL_LAT + 1));
            end
        end
    endtask

    task automatic test_busy_start;
        int cyc;
        int extra;
        @(negedge clk);
        bus.start = 1'b1; bus.x_in = 15'd2048;
        @(negedge clk);
        cyc = 1;
        // Keep hammering start with a different argument while busy.
        bus.x_in = 15'd1419;
        while (!bus.done && cyc < 400) begin
            bus.start = cyc[0];
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checks++;
        if (!bus.done || bus.y !== 40'd178181 || bus.iter_cnt !== 5'd5 || cyc != 13) begin
            errors++;
            $display("FAIL busy_start done=%b y=%0d it=%0d cyc=%0d exp 1 178181 5 13",
                     bus.done, bus.y, bus.iter_cnt, cyc);
        end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL busy_start_idle got %0d active cycles exp 0", extra);
        end
    endtask

    task automatic test_rst_midrun;
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.x_in = 15'd2048;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.data !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.y !== '0 || bus.iter_cnt !== '0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid data=%0d busy=%b done=%b y=%0h it=%0d err=%b exp all 0",
                     bus.data, bus.busy, bus.done, bus.y, bus.iter_cnt, bus.err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.y != '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_mid_quiet got %0d active cycles exp 0", seen);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x_in  = '0;
        test_reset();
        test_directed();
        test_bad_select();
        test_random();
        test_busy_start();
        test_rst_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
